// File: rtl/lu_pkg.sv
// Shared definitions for the logic unit: operation encodings, FSM states and
// the default busy-hold length.
package lu_pkg;

  typedef enum logic [2:0] {
    LU_AND   = 3'b000,
    LU_OR    = 3'b001,
    LU_XOR   = 3'b010,
    LU_NAND  = 3'b011,
    LU_NOR   = 3'b100,
    LU_XNOR  = 3'b101,
    LU_NOTA  = 3'b110,
    LU_PASSB = 3'b111
  } lu_op_e;

  typedef enum logic {
    LU_IDLE = 1'b0,
    LU_BUSY = 1'b1
  } lu_state_e;

  localparam int LU_HOLD_DEFAULT = 3;

endpackage

// File: rtl/lu_op.sv
// Combinational bitwise operation decoder: y = f(op, a, b) for every 3-bit op code.
module lu_op
  import lu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (lu_op_e'(op))
      LU_AND:   y = a & b;
      LU_OR:    y = a | b;
      LU_XOR:   y = a ^ b;
      LU_NAND:  y = ~(a & b);
      LU_NOR:   y = ~(a | b);
      LU_XNOR:  y = ~(a ^ b);
      LU_NOTA:  y = ~a;
      LU_PASSB: y = b;
    endcase
  end

endmodule

// File: rtl/logic_unit.sv
// Logic unit: latches f(op, data1, data2) on accept, then holds busy for HOLD cycles
// with a done pulse in the last one. Define LOGIC_UNIT_FLAGS_EN to add zero/parity outputs.
module logic_unit
  import lu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HOLD  = LU_HOLD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] out,
  output logic             busy,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic             zero,
  output logic             parity,
`endif
  output logic             done
);

  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);

  lu_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic             busy_q;
  logic             done_q;

  lu_op #(.WIDTH(WIDTH)) u_op (
    .op (op),
    .a  (data1),
    .b  (data2),
    .y  (out_d)
  );

`ifdef LOGIC_UNIT_FLAGS_EN
  logic zero_q;
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
    end else if (state_q == LU_IDLE && start) begin
      zero_q   <= (out_d == '0);
      parity_q <= ^out_d;
    end
  end

  assign zero   = zero_q;
  assign parity = parity_q;
`endif

  // done is registered one step ahead: it rises on the edge that brings the count to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LU_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        LU_IDLE: begin
          if (start) begin
            out_q   <= out_d;
            state_q <= LU_BUSY;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            done_q  <= (CNT_LOAD == '0);
          end
        end
        LU_BUSY: begin
          if (cnt_q == '0) begin
            state_q <= LU_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q - CW'(1);
            done_q <= (cnt_q == CW'(1));
          end
        end
      endcase
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_logic_unit.sv
// Directed plus random stimulus for logic_unit (8-bit/HOLD=3 and 16-bit/HOLD=1
// instances) checked against a truth-table / remaining-busy-cycles reference model.
module tb_logic_unit;

  localparam int H1 = 3;
  localparam int H2 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start1, start2;
  logic [2:0]  op1, op2;
  logic [7:0]  a1, b1, out1;
  logic [15:0] a2, b2, out2;
  logic        busy1, done1, busy2, done2;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic        zero1, parity1, zero2, parity2;
`endif

  int errors = 0;
  int checks = 0;

  int          m1_left, m2_left;
  logic [63:0] m1_out, m2_out;

  logic [7:0] exp30 [8] = '{8'h12, 8'h7B, 8'h69, 8'hED, 8'h84, 8'h96, 8'hA5, 8'h33};

  logic_unit #(.WIDTH(8), .HOLD(H1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start1),
    .op     (op1),
    .data1  (a1),
    .data2  (b1),
    .out    (out1),
    .busy   (busy1),
`ifdef LOGIC_UNIT_FLAGS_EN
    .zero   (zero1),
    .parity (parity1),
`endif
    .done   (done1)
  );

  logic_unit #(.WIDTH(16), .HOLD(H2)) dut2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start2),
    .op     (op2),
    .data1  (a2),
    .data2  (b2),
    .out    (out2),
    .busy   (busy2),
`ifdef LOGIC_UNIT_FLAGS_EN
    .zero   (zero2),
    .parity (parity2),
`endif
    .done   (done2)
  );

  // Per-bit truth tables indexed by {a,b}: bit3=a1b1, bit2=a1b0, bit1=a0b1, bit0=a0b0.
  function automatic logic [63:0] ref_f(input logic [2:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input int w);
    logic [3:0]  tt;
    logic [63:0] r;
    r  = '0;
    tt = 4'b0000;
    case (op)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0110;
      3'd3: tt = 4'b0111;
      3'd4: tt = 4'b0001;
      3'd5: tt = 4'b1001;
      3'd6: tt = 4'b0011;
      3'd7: tt = 4'b1010;
    endcase
    for (int i = 0; i < w; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m1_left = 0;
    m2_left = 0;
    m1_out  = '0;
    m2_out  = '0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m1_left == 0) begin
        if (start1) begin
          m1_out  = ref_f(op1, 64'(a1), 64'(b1), 8);
          m1_left = H1;
        end
      end else begin
        m1_left--;
      end
      if (m2_left == 0) begin
        if (start2) begin
          m2_out  = ref_f(op2, 64'(a2), 64'(b2), 16);
          m2_left = H2;
        end
      end else begin
        m2_left--;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out1"},  64'(out1),  m1_out);
    chk({tag, ".busy1"}, 64'(busy1), 64'(m1_left > 0));
    chk({tag, ".done1"}, 64'(done1), 64'(m1_left == 1));
    chk({tag, ".out2"},  64'(out2),  m2_out);
    chk({tag, ".busy2"}, 64'(busy2), 64'(m2_left > 0));
    chk({tag, ".done2"}, 64'(done2), 64'(m2_left == 1));
`ifdef LOGIC_UNIT_FLAGS_EN
    chk({tag, ".zero1"},   64'(zero1),   64'(m1_out == 64'd0));
    chk({tag, ".parity1"}, 64'(parity1), 64'(^m1_out));
    chk({tag, ".zero2"},   64'(zero2),   64'(m2_out == 64'd0));
    chk({tag, ".parity2"}, 64'(parity2), 64'(^m2_out));
`endif
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic wait_idle1(input string tag);
    while (m1_left > 0) tick(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start1 = 1'b0; op1 = 3'd0; a1 = 8'h00; b1 = 8'h00;
    start2 = 1'b0; op2 = 3'd0; a2 = 16'h0; b2 = 16'h0;
    model_reset();
    #1;
    check_all("reset");
    chk("reset_out1", 64'(out1), 64'h0);
    start1 = 1'b1;
    tick("rst_hold");
    tick("rst_hold");
    start1 = 1'b0;
    rst_n  = 1'b1;
    tick("post_rst");
    chk("post_rst_busy1", 64'(busy1), 64'h0);

    // Basic XOR accept with three busy cycles
    start1 = 1'b1; op1 = 3'b010; a1 = 8'hF0; b1 = 8'h3C;
    tick("xor_acc");
    chk("xor_out", 64'(out1), 64'hCC);
    chk("xor_busy_c1", 64'(busy1), 64'h1);
    chk("xor_done_c1", 64'(done1), 64'h0);
    start1 = 1'b0;
    tick("xor_c2");
    chk("xor_done_c2", 64'(done1), 64'h0);
    tick("xor_c3");
    chk("xor_busy_c3", 64'(busy1), 64'h1);
    chk("xor_done_c3", 64'(done1), 64'h1);
    tick("xor_idle");
    chk("xor_busy_end", 64'(busy1), 64'h0);
    chk("xor_done_end", 64'(done1), 64'h0);

    // Start held high: re-accepts every HOLD+1 cycles, data toggling while busy
    start1 = 1'b1; op1 = 3'b000; a1 = 8'hAA; b1 = 8'h0F;
    tick("hold_acc");
    chk("hold_out", 64'(out1), 64'h0A);
    for (int i = 0; i < 12; i++) begin
      if (m1_left == 0) begin
        a1 = 8'hAA; b1 = 8'h0F;
      end else begin
        a1 = 8'($urandom); b1 = 8'($urandom); op1 = 3'($urandom);
      end
      if (m1_left == 0) op1 = 3'b000;
      tick("hold_loop");
      chk("hold_out_stable", 64'(out1), 64'h0A);
      chk("hold_busy_period", 64'(busy1), 64'((i % 4) != 2));
    end
    start1 = 1'b0;
    wait_idle1("hold_drain");

    // Sweep all op codes
    for (int k = 0; k < 8; k++) begin
      start1 = 1'b1; op1 = 3'(k); a1 = 8'h5A; b1 = 8'h33;
      tick("sweep_acc");
      chk($sformatf("sweep_op%0d", k), 64'(out1), 64'(exp30[k]));
      start1 = 1'b0;
      wait_idle1("sweep_drain");
    end

    // Asynchronous reset in the second busy cycle
    start1 = 1'b1; op1 = 3'b001; a1 = 8'h81; b1 = 8'h10;
    tick("ar_acc");
    start1 = 1'b0;
    tick("ar_busy2");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_out",  64'(out1),  64'h0);
    chk("ar_busy", 64'(busy1), 64'h0);
    chk("ar_done", 64'(done1), 64'h0);
    check_all("ar_async");
    #1;
    rst_n = 1'b1;
    start1 = 1'b1; op1 = 3'b111; b1 = 8'h3C;
    tick("ar_reacc");
    chk("ar_reacc_out",  64'(out1),  64'h3C);
    chk("ar_reacc_busy", 64'(busy1), 64'h1);
    start1 = 1'b0;
    wait_idle1("ar_drain");

    // 16-bit, HOLD=1 instance: busy and done together, accepts every 2 cycles
    start2 = 1'b1; op2 = 3'b110; a2 = 16'h00FF; b2 = 16'($urandom);
    tick("w16_acc");
    chk("w16_out",  64'(out2),  64'hFF00);
    chk("w16_busy", 64'(busy2), 64'h1);
    chk("w16_done", 64'(done2), 64'h1);
    for (int i = 0; i < 4; i++) begin
      tick("w16_b2b");
      chk("w16_b2b_busy", 64'(busy2), 64'(i % 2));
    end
    start2 = 1'b0;
    tick("w16_end");

    // Flag cases
    start1 = 1'b1; op1 = 3'b010; a1 = 8'h77; b1 = 8'h77;
    tick("flag_zero");
    chk("flag_zero_out", 64'(out1), 64'h0);
`ifdef LOGIC_UNIT_FLAGS_EN
    chk("flag_zero_z", 64'(zero1),   64'h1);
    chk("flag_zero_p", 64'(parity1), 64'h0);
`endif
    start1 = 1'b0;
    wait_idle1("flag_drain");
    start1 = 1'b1; a1 = 8'h01; b1 = 8'h00;
    tick("flag_par");
    chk("flag_par_out", 64'(out1), 64'h01);
`ifdef LOGIC_UNIT_FLAGS_EN
    chk("flag_par_z", 64'(zero1),   64'h0);
    chk("flag_par_p", 64'(parity1), 64'h1);
`endif
    start1 = 1'b0;
    wait_idle1("flag_drain2");

    // Random traffic on both instances
    for (int i = 0; i < 300; i++) begin
      start1 = 1'($urandom_range(0, 1));
      op1    = 3'($urandom);
      a1     = 8'($urandom);
      b1     = 8'($urandom);
      start2 = 1'($urandom_range(0, 1));
      op2    = 3'($urandom);
      a2     = 16'($urandom);
      b2     = 16'($urandom);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
